// File: rtl/viterbi_pkg.sv
// Shared constants and types for the Viterbi decoder display path.
package viterbi_pkg;

  localparam int ADDR_W    = 10;
  localparam int MEM_DEPTH = 1024;
  localparam int BYTE_W    = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    OUT  = 2'd2,
    FIN  = 2'd3
  } disp_pack_state_t;

endpackage

// File: rtl/disp_byte_packer.sv
// Reads a run of decoded bits from the 1-bit display memory (synchronous
// read, one address per cycle), packs them into bytes and streams the
// bytes out over valid/ready. Reads stall while a byte waits in OUT, so
// backpressure never loses bits.
module disp_byte_packer #(
  parameter int ADDR_W    = viterbi_pkg::ADDR_W,
  parameter int BYTE_W    = viterbi_pkg::BYTE_W,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   nbits,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_d_o,
  output logic [BYTE_W-1:0] byte_o,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              busy,
  output logic              done
);

  import viterbi_pkg::*;

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FULL_RUN = CNT_W'(1) << ADDR_W;
  localparam logic [CNT_W-1:0] BYTE_CNT = CNT_W'(BYTE_W);

  disp_pack_state_t state_reg, state_next;

  logic [ADDR_W-1:0] addr_reg;
  logic [CNT_W-1:0]  remaining_reg;
  logic [CNT_W-1:0]  issued_reg;
  logic [CNT_W-1:0]  captured_reg;
  logic              pending_reg;
  logic [BYTE_W-1:0] shift_reg;
  logic [BYTE_W-1:0] byte_reg;
  logic              valid_reg;
  logic              done_reg;

  logic [CNT_W-1:0]  nbits_clamped;
  logic [CNT_W-1:0]  byte_limit;
  logic [CNT_W-1:0]  cap_next;
  logic [CNT_W-1:0]  pad_amt;
  logic [CNT_W-1:0]  rem_after;
  logic [BYTE_W-1:0] shift_next;
  logic [BYTE_W-1:0] padded;
  logic              issue_en;
  logic              capture_en;
  logic              byte_last;
  logic              accept;

  // Run bookkeeping: clamp the request, size of the current byte, handshake.
  always_comb begin
    nbits_clamped = (nbits > FULL_RUN) ? FULL_RUN : nbits;
    byte_limit    = (remaining_reg < BYTE_CNT) ? remaining_reg : BYTE_CNT;
    issue_en      = (state_reg == READ) && (issued_reg < byte_limit);
    capture_en    = (state_reg == READ) && pending_reg;
    cap_next      = captured_reg + 1'b1;
    byte_last     = capture_en && (cap_next == byte_limit);
    accept        = (state_reg == OUT) && valid_reg && byte_ready;
    rem_after     = remaining_reg - captured_reg;
  end

  // Shift the incoming bit in and right-align (or left-align) a partial byte
  // so that the unfilled positions come out as zeros.
  always_comb begin
    shift_next = shift_reg;
    padded     = '0;
    pad_amt    = BYTE_CNT - cap_next;
    if (LSB_FIRST) begin
      shift_next = {mem_d_o, shift_reg[BYTE_W-1:1]};
      padded     = shift_next >> pad_amt;
    end else begin
      shift_next = {shift_reg[BYTE_W-2:0], mem_d_o};
      padded     = shift_next << pad_amt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: if (start) state_next = (nbits_clamped == '0) ? FIN : READ;
      READ: if (byte_last) state_next = OUT;
      OUT:  if (accept) state_next = (rem_after == '0) ? FIN : READ;
      FIN:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Address issue, bit capture and output byte registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_reg      <= '0;
      remaining_reg <= '0;
      issued_reg    <= '0;
      captured_reg  <= '0;
      pending_reg   <= 1'b0;
      shift_reg     <= '0;
      byte_reg      <= '0;
      valid_reg     <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= (state_reg == FIN);
      unique case (state_reg)
        IDLE: begin
          if (start) begin
            addr_reg      <= base_addr;
            remaining_reg <= nbits_clamped;
            issued_reg    <= '0;
            captured_reg  <= '0;
            pending_reg   <= 1'b0;
            shift_reg     <= '0;
          end
        end
        READ: begin
          // The memory samples addr_reg on this edge; its data is
          // captured one edge later under pending_reg.
          pending_reg <= issue_en;
          if (issue_en) begin
            addr_reg   <= addr_reg + 1'b1;
            issued_reg <= issued_reg + 1'b1;
          end
          if (capture_en) begin
            shift_reg    <= shift_next;
            captured_reg <= cap_next;
            if (byte_last) begin
              byte_reg  <= padded;
              valid_reg <= 1'b1;
            end
          end
        end
        OUT: begin
          if (accept) begin
            valid_reg     <= 1'b0;
            remaining_reg <= rem_after;
            issued_reg    <= '0;
            captured_reg  <= '0;
            shift_reg     <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_addr   = addr_reg;
  assign byte_o     = byte_reg;
  assign byte_valid = valid_reg;
  assign busy       = (state_reg != IDLE);
  assign done       = done_reg;

endmodule

// File: tb/tb_disp_byte_packer.sv
// Bench for disp_byte_packer: a 1024x1 sync-read memory behind the busy
// address mux, directed runs, and a scoreboard monitor on the byte stream.
module tb_disp_byte_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  base_addr = '0;
  logic [10:0] nbits = '0;
  logic [9:0]  mem_addr;
  logic        mem_d_o;
  logic [7:0]  byte_o;
  logic        byte_valid;
  logic        byte_ready = 1'b0;
  logic        busy;
  logic        done;

  logic        wr = 1'b0;
  logic [9:0]  wr_addr = '0;
  logic        wr_data = 1'b0;
  logic        mem [1024];
  logic [9:0]  mux_addr;

  int errors = 0;
  int checks = 0;
  int hs_cnt = 0;
  logic [7:0] sb_q[$];

  always #5 clk = ~clk;

  disp_byte_packer dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .nbits(nbits),
    .mem_addr(mem_addr), .mem_d_o(mem_d_o), .byte_o(byte_o),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .busy(busy), .done(done)
  );

  // Display memory model: write port for preload, sync read.
  assign mux_addr = busy ? mem_addr : wr_addr;
  always @(posedge clk) begin
    if (wr) mem[wr_addr] <= wr_data;
    mem_d_o <= mem[mux_addr];
  end

  function automatic bit pat(int i);
    logic [7:0] head;
    head = 8'b0100_1101;
    if (i < 8) return head[i];
    return bit'(((i * 37) ^ (i >> 2)) >> 1);
  endfunction

  function automatic logic [7:0] exp_byte(int base, int n, int k);
    logic [7:0] b;
    b = '0;
    for (int j = 0; j < 8; j++)
      if (k * 8 + j < n) b[j] = pat((base + k * 8 + j) % 1024);
    return b;
  endfunction

  task automatic check(string name, int got, int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses start for one edge; optionally pushes the expected bytes.
  task automatic do_start(int base, int nb, bit push);
    int n;
    n = (nb > 1024) ? 1024 : nb;
    if (push)
      for (int k = 0; k < (n + 7) / 8; k++) sb_q.push_back(exp_byte(base, n, k));
    base_addr = 10'(base);
    nbits     = 11'(nb);
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_done(int max);
    int n = 0;
    while (done !== 1'b1 && n < max) begin
      tick();
      n++;
    end
    check("done_timeout", int'(done), 1);
    tick();
  endtask

  // Scoreboard monitor: compares every accepted byte with the queue head.
  always @(negedge clk) begin
    if (!rst && byte_valid && byte_ready) begin
      hs_cnt++;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got byte 0x%02h expected no byte", byte_o);
      end else begin
        logic [7:0] e;
        e = sb_q.pop_front();
        if (byte_o !== e) begin
          errors++;
          $display("FAIL sb_byte: got 0x%02h expected 0x%02h", byte_o, e);
        end else begin
          $display("byte %0d: 0x%02h ok", hs_cnt, byte_o);
        end
      end
    end
  end

  initial begin
    int n;
    int hs0;
    logic [7:0] b0;

    // Reset state.
    repeat (3) tick();
    check("rst_mem_addr", int'(mem_addr), 0);
    check("rst_byte_o", int'(byte_o), 0);
    check("rst_byte_valid", int'(byte_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    rst = 1'b0;
    tick();

    // Preload the display memory through its write port.
    for (int i = 0; i < 1024; i++) begin
      wr = 1'b1; wr_addr = 10'(i); wr_data = pat(i);
      tick();
    end
    wr = 1'b0; wr_addr = '0;
    tick();

    // 1) First byte latency, value and done timing.
    byte_ready = 1'b1;
    do_start(0, 8, 1'b1);
    n = 0;
    while (byte_valid !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("t1_latency", n, 9);
    check("t1_byte", int'(byte_o), 8'h4D);
    tick();
    check("t1_fin_done", int'(done), 0);
    check("t1_fin_busy", int'(busy), 1);
    tick();
    check("t1_done_pulse", int'(done), 1);
    check("t1_idle_busy", int'(busy), 0);
    tick();
    check("t1_done_drop", int'(done), 0);

    // 2) Two bytes, the second zero-padded.
    hs0 = hs_cnt;
    do_start(100, 12, 1'b1);
    wait_done(100);
    check("t2_handshakes", hs_cnt - hs0, 2);

    // 3) Address wrap 1020..1023,0..3.
    do_start(1020, 8, 1'b1);
    check("t3_addr0", int'(mem_addr), 1020);
    for (int k = 1; k < 8; k++) begin
      tick();
      check("t3_addr", int'(mem_addr), (1020 + k) % 1024);
    end
    wait_done(100);

    // 4) Backpressure holds byte and address.
    byte_ready = 1'b0;
    do_start(200, 16, 1'b1);
    n = 0;
    while (byte_valid !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    b0 = exp_byte(200, 16, 0);
    for (int k = 0; k < 20; k++) begin
      check("t4_valid_hold", int'(byte_valid), 1);
      check("t4_byte_hold", int'(byte_o), int'(b0));
      check("t4_addr_frozen", int'(mem_addr), 208);
      tick();
    end
    byte_ready = 1'b1;
    wait_done(100);

    // 5) Empty run, then start while busy ignored.
    byte_ready = 1'b1;
    hs0 = hs_cnt;
    do_start(7, 0, 1'b0);
    check("t5_fin_valid", int'(byte_valid), 0);
    check("t5_fin_done", int'(done), 0);
    tick();
    check("t5_done_pulse", int'(done), 1);
    tick();
    check("t5_done_drop", int'(done), 0);
    check("t5_no_bytes", hs_cnt - hs0, 0);
    hs0 = hs_cnt;
    do_start(300, 16, 1'b1);
    repeat (3) tick();
    base_addr = 10'd0; nbits = 11'd8; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(100);
    check("t5_busy_start_ignored", hs_cnt - hs0, 2);

    // 6) Asynchronous reset mid-READ, then a clamped full-memory run.
    do_start(40, 64, 1'b0);
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    check("t6_rst_mem_addr", int'(mem_addr), 0);
    check("t6_rst_byte_valid", int'(byte_valid), 0);
    check("t6_rst_byte_o", int'(byte_o), 0);
    check("t6_rst_busy", int'(busy), 0);
    check("t6_rst_done", int'(done), 0);
    tick();
    rst = 1'b0;
    tick();
    hs0 = hs_cnt;
    do_start(5, 2000, 1'b1);
    wait_done(3000);
    check("t6_clamp_bytes", hs_cnt - hs0, 128);
    check("sb_leftover", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
